mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised modulo up/down counter with synchronous load, count enable, clock-enable prescaler, terminal-count and wrap outputs.
- Successor to the fixed-width lab counter: width, modulus and prescale are configurable, and count direction is selectable at run time.
- Used as a timebase and event counter by the lab top levels.
- Single clock domain.

Parameters:
- WIDTH, 12, counter width in bits; must be ≥ 1.
- MODULUS, 2**WIDTH, count range is 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2**WIDTH.
- PRESCALE, 1, number of enabled cycles per count step; must be ≥ 1.

Ports:
- CLK  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; it gates the prescaler.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- up_dn  input  1  count direction; 1 = up, 0 = down.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational from q and up_dn.
- wrap  output  1  one-cycle registered pulse after a wrap.
- zero  output  1  high when q == 0, combinational.

Behaviour:
- Reset (asynchronous, immediate on assertion):
  - q = 0, wrap = 0, prescaler count = 0.
  - tc therefore = ~up_dn, and zero = 1.
- Priority at each CLK edge: reset > load > count step > hold.
- MAX = MODULUS-1, computed at WIDTH bits.
- Load:
  - Takes effect at the next edge, regardless of en.
  - q <= load_val if load_val ≤ MAX, else q <= MAX (clamp).
  - The prescaler count clears to 0.
  - wrap <= 0.
- Prescaler:
  - pcnt counts 0..PRESCALE-1, advancing only on cycles with en = 1.
  - tick = en && (pcnt == PRESCALE-1).
  - On tick, pcnt <= 0; with en = 0, pcnt holds.
  - With PRESCALE = 1, tick = en and pcnt is not synthesised.
- Count step, taken on tick with load = 0:
  - Up: q == MAX → q <= 0 and wrap <= 1; otherwise q <= q+1.
  - Down: q == 0 → q <= MAX and wrap <= 1; otherwise q <= q-1.
- wrap is 0 on every edge that does not perform a wrap, so it is exactly one cycle wide and appears the cycle after the wrapping edge.
- tc = (up_dn && q == MAX) || (!up_dn && q == 0). tc therefore predicts that the next tick wraps.
- Direction change: up_dn is sampled at the edge, so a change takes effect on the next tick and the prescaler phase is unaffected.
- Latency: q changes on the edge that samples tick or load. There is no pipeline.
- Simultaneous load and tick: the load wins, no step is taken and wrap = 0.
- Reset mid-count: q and the prescaler clear immediately, and any pending wrap pulse is killed.
- MODULUS == 2**WIDTH: wrap arithmetic must not rely on WIDTH+1-bit compares overflowing; MAX stays all-ones.

Optional Feature:
- Macro MOD_COUNTER_SATURATE_EN.
- Defined:
  - Up at MAX: q holds at MAX instead of wrapping.
  - Down at 0: q holds at 0.
  - wrap is never asserted (tied 0).
  - tc keeps its definition, meaning "at limit".
- Undefined: modulo wrap behaviour as described in Behaviour.

Decomposition:
- Shared package mod_counter_pkg:
  - Direction constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0.
  - A function computing the clamped MAX from WIDTH/MODULUS.
- One sub-module, tick_prescaler:
  - Ports CLK, reset, en, clr, tick.
  - Parameter PRESCALE.
  - Implements pcnt and tick generation; clr is driven by load.

Test Plan:
- Reset/idle: WIDTH=4, MODULUS=10, PRESCALE=1. Assert reset for 2 cycles, then en = 0 for 5 cycles → q = 0, zero = 1, wrap = 0, q holds 0.
- Up wrap: en = 1, up_dn = 1 from q = 0 for 10 cycles → q steps 1..9 then 0; tc = 1 while q == 9; wrap = 1 for exactly the one cycle when q first reads 0.
- Down wrap and direction change: from q = 2, up_dn = 0, en = 1 → q = 1, 0, 9 and wrap pulses once. Then set up_dn = 1 → q = 0 and wrap pulses once.
- Load priority and clamp:
  - load = 1, load_val = 7, en = 1 on the same cycle → q = 7, no step, wrap = 0.
  - load_val = 13 → q = 9.
- Prescaler: PRESCALE = 3, en = 1 continuously → q increments every 3rd cycle. Deassert en for 4 cycles mid-phase → the phase resumes exactly. A load mid-phase → the next step comes 3 enabled cycles later.
- Asynchronous reset mid-operation and saturate build:
  - Assert reset between edges with q = 5 → q = 0 before the next edge.
  - With MOD_COUNTER_SATURATE_EN defined and q = 9 counting up → q stays 9, wrap stays 0, tc = 1.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo counter.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Largest count value: MODULUS-1, clamped to what WIDTH bits can hold.
  function automatic longint unsigned calc_max(input int unsigned width,
                                               input longint unsigned modulus);
    longint unsigned full;
    full = (64'd1 << width) - 64'd1;
    if (modulus == 0 || (modulus - 64'd1) > full) return full;
    return modulus - 64'd1;
  endfunction

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles; clr restarts the phase.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = ^{CLK, reset, clr};
    assign tick = en;
  end else begin : g_count
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;

    always_comb begin
      pcnt_d = pcnt_q;
      if (clr) begin
        pcnt_d = '0;
      end else if (en) begin
        pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + PW'(1);
      end
    end

    always_ff @(posedge CLK or posedge reset) begin
      if (reset) pcnt_q <= '0;
      else       pcnt_q <= pcnt_d;
    end

    assign tick = en && (pcnt_q == LAST);
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with load, prescaled enable, tc and wrap.
// Define MOD_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int MODULUS  = 2**WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(calc_max(WIDTH, MODULUS));

  logic             tick;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK   (CLK),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (tick)
  );

  // Limits are compared by equality so MODULUS == 2**WIDTH needs no extra bit.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = (load_val > MAX) ? MAX : load_val;
    end else if (tick) begin
      if (up_dn == DIR_UP) begin
        if (q_q == MAX) begin
`ifdef MOD_COUNTER_SATURATE_EN
          q_d = MAX;
`else
          q_d    = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
`ifdef MOD_COUNTER_SATURATE_EN
          q_d = '0;
`else
          q_d    = MAX;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign zero = (q_q == '0);
  assign tc   = ((up_dn == DIR_UP) && (q_q == MAX)) || ((up_dn == DIR_DOWN) && (q_q == '0));

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench: two counters (PRESCALE 1 and 3) share stimulus against a behavioural model.
module tb_mod_counter;

  localparam int W = 4;
  localparam int M = 10;
  localparam int P3 = 3;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic         up_dn = 1'b1;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] q1, q3;
  logic         tc1, tc3, wrap1, wrap3, zero1, zero3;

  always #5 CLK = ~CLK;

  mod_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) dut1 (
    .CLK(CLK), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .q(q1), .tc(tc1), .wrap(wrap1), .zero(zero1)
  );

  mod_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(P3)) dut3 (
    .CLK(CLK), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .q(q3), .tc(tc3), .wrap(wrap3), .zero(zero3)
  );

  typedef struct {
    int q1; bit w1; bit tc1; bit z1;
    int q3; bit w3; bit tc3; bit z3;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: count values, pending wrap flags, enabled-cycle phase of the /3 counter.
  int m_q1 = 0, m_q3 = 0, m_ph3 = 0;
  bit m_w1 = 0, m_w3 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void step(input int q, input bit tick, output int nq, output bit w);
    w  = 0;
    nq = q;
    if (load) begin
      nq = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
    end else if (tick) begin
      if (up_dn) begin
`ifdef MOD_COUNTER_SATURATE_EN
        nq = (q == M - 1) ? q : q + 1;
`else
        nq = (q + 1) % M;
        w  = (q == M - 1);
`endif
      end else begin
`ifdef MOD_COUNTER_SATURATE_EN
        nq = (q == 0) ? 0 : q - 1;
`else
        nq = (q + M - 1) % M;
        w  = (q == 0);
`endif
      end
    end
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.q1 = m_q1; e.w1 = m_w1; e.z1 = (m_q1 == 0);
    e.tc1 = up_dn ? (m_q1 == M - 1) : (m_q1 == 0);
    e.q3 = m_q3; e.w3 = m_w3; e.z3 = (m_q3 == 0);
    e.tc3 = up_dn ? (m_q3 == M - 1) : (m_q3 == 0);
    return e;
  endfunction

  function automatic void model_edge();
    int  nq;
    bit  w, tick3;
    if (reset) begin
      m_q1 = 0; m_w1 = 0; m_q3 = 0; m_w3 = 0; m_ph3 = 0;
      return;
    end
    step(m_q1, en, nq, w);
    m_q1 = nq; m_w1 = w;
    tick3 = en && (m_ph3 == P3 - 1);
    step(m_q3, tick3, nq, w);
    m_q3 = nq; m_w3 = w;
    if (load)    m_ph3 = 0;
    else if (en) m_ph3 = (m_ph3 + 1) % P3;
  endfunction

  task automatic cyc(input bit r, input bit e, input bit l, input int lv, input bit u);
    @(negedge CLK);
    reset = r; en = e; load = l; load_val = W'(lv); up_dn = u;
    model_edge();
    sb.push_back(snapshot());
  endtask

  // Reset asserted between edges must clear the outputs before the next edge.
  task automatic async_reset();
    @(negedge CLK);
    en = 1'b1; load = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_q1", q1, 0);
    chk("async_q3", q3, 0);
    chk("async_wrap1", wrap1, 0);
    chk("async_zero1", zero1, 1);
    model_edge();
    sb.push_back(snapshot());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("q1", q1, e.q1);
        chk("wrap1", wrap1, e.w1);
        chk("tc1", tc1, e.tc1);
        chk("zero1", zero1, e.z1);
        chk("q3", q3, e.q3);
        chk("wrap3", wrap3, e.w3);
        chk("tc3", tc3, e.tc3);
        chk("zero3", zero3, e.z3);
      end
    end
  end

  initial begin : driver
    #1;
    chk("reset_q", q1, 0);
    chk("reset_tc", tc1, 0);
    chk("reset_zero", zero1, 1);

    repeat (2) cyc(1, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 1);
    repeat (10) cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 2, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 7, 1);
    cyc(0, 0, 1, 13, 1);
    cyc(0, 1, 1, 0, 1);
    repeat (8) cyc(0, 1, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 1);
    repeat (4) cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 4, 1);
    repeat (6) cyc(0, 1, 0, 0, 1);
    repeat (12) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 5, 1);
    cyc(0, 0, 0, 0, 1);
    async_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 9, 1);
    repeat (4) cyc(0, 1, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 15)),
          ($urandom_range(0, 7) != 0) ? up_dn : ~up_dn);
    end
    cyc(0, 0, 0, 0, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CLK);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
